fizzbuzz_checker: RTL and testbench

- Receive-side monitor for the fizz/buzz/fizzbuzz flag stream.
- Consumes one flag triple per valid beat and acquires phase lock, including the MAX_CYCLES wrap point.
- After lock, reports the recovered position and flags every beat that deviates from the expected sequence.
- Sits on the sink end of the flag bus, as an in-system checker and as a bench scoreboard.

---
 rtl/fizzbuzz_pkg.sv | 37 +++
 rtl/fizzbuzz_expect.sv | 62 ++++++
 rtl/fizzbuzz_checker.sv | 149 ++++++++++++++
 tb/tb_fizzbuzz_checker.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and elaboration-time helpers for the fizz/buzz stream checker.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } fb_state_e;

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int unsigned lcm(input int unsigned a, input int unsigned b);
        return (a / gcd(a, b)) * b;
    endfunction

    // Beats from the last fizzbuzz before the wrap to position 0.
    function automatic int unsigned wrap_gap(input int unsigned fizz_p,
                                             input int unsigned buzz_p,
                                             input int unsigned max_cycles);
        int unsigned l;
        l = lcm(fizz_p, buzz_p);
        return max_cycles - l * ((max_cycles - 1) / l);
    endfunction

endpackage

// File: rtl/fizzbuzz_expect.sv
// Expected-sequence generator: position plus fizz/buzz phase counters.
module fizzbuzz_expect
    import fizzbuzz_pkg::*;
#(
    parameter int unsigned FIZZ       = 3,
    parameter int unsigned BUZZ       = 5,
    parameter int unsigned MAX_CYCLES = 100
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          load,
    input  logic                          advance,
    input  logic                          wrap_en,
    output logic                          exp_fizz,
    output logic                          exp_buzz,
    output logic                          exp_fizzbuzz,
    output logic [$clog2(MAX_CYCLES)-1:0] position
);

    localparam int unsigned PW = $clog2(MAX_CYCLES);
    localparam int unsigned FW = $clog2(FIZZ);
    localparam int unsigned BW = $clog2(BUZZ);

    // Registers hold the phase of the last accepted beat; the *_nxt values
    // describe the beat currently on the bus.
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nxt;
    logic [FW-1:0] fph;
    logic [FW-1:0] fph_nxt;
    logic [BW-1:0] bph;
    logic [BW-1:0] bph_nxt;
    logic          pos_wrap;

    always_comb begin
        pos_wrap = (pos == PW'(MAX_CYCLES - 1));
        pos_nxt  = pos_wrap ? '0 : pos + PW'(1);
        fph_nxt  = (fph == FW'(FIZZ - 1)) ? '0 : fph + FW'(1);
        bph_nxt  = (bph == BW'(BUZZ - 1)) ? '0 : bph + BW'(1);
        if (wrap_en && pos_wrap) begin
            fph_nxt = '0;
            bph_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            pos <= '0;
            fph <= '0;
            bph <= '0;
        end else if (advance) begin
            pos <= pos_nxt;
            fph <= fph_nxt;
            bph <= bph_nxt;
        end
    end

    assign exp_fizz     = (fph_nxt == '0);
    assign exp_buzz     = (bph_nxt == '0);
    assign exp_fizzbuzz = exp_fizz & exp_buzz;
    assign position     = pos;

endmodule

// File: rtl/fizzbuzz_checker.sv
// Sink-side checker: acquires phase lock on the fizz/buzz flag stream and
// reports position, per-beat deviations and a saturating error count.
module fizzbuzz_checker
    import fizzbuzz_pkg::*;
#(
    parameter int unsigned FIZZ        = 3,
    parameter int unsigned BUZZ        = 5,
    parameter int unsigned MAX_CYCLES  = 100,
    parameter int unsigned LOSS_THRESH = 3,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic                          fizz,
    input  logic                          buzz,
    input  logic                          fizzbuzz,
    output logic                          locked,
    output logic [$clog2(MAX_CYCLES)-1:0] position,
    output logic                          mismatch,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam int unsigned L        = lcm(FIZZ, BUZZ);
    localparam int unsigned WRAP_GAP = wrap_gap(FIZZ, BUZZ, MAX_CYCLES);
    localparam int unsigned GW       = $clog2(L + 1);
    localparam int unsigned MW       = $clog2(LOSS_THRESH + 1);

    fb_state_e            state;
    fb_state_e            state_nxt;
    logic [GW-1:0]        gap;
    logic [GW-1:0]        gap_nxt;
    logic [GW-1:0]        gap_inc;
    logic [MW-1:0]        miss_run;
    logic [MW-1:0]        miss_nxt;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ERR_CNT_W-1:0] err_nxt;
    logic                 mismatch_q;
    logic                 mismatch_nxt;

    logic exp_load;
    logic exp_adv;
    logic exp_wrap_en;
    logic exp_fizz;
    logic exp_buzz;
    logic exp_fizzbuzz;
    logic consistent;
    logic pattern_bad;
    logic flag_diff;

    fizzbuzz_expect #(
        .FIZZ       (FIZZ),
        .BUZZ       (BUZZ),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_expect (
        .clk          (clk),
        .resetn       (resetn),
        .load         (exp_load),
        .advance      (exp_adv),
        .wrap_en      (exp_wrap_en),
        .exp_fizz     (exp_fizz),
        .exp_buzz     (exp_buzz),
        .exp_fizzbuzz (exp_fizzbuzz),
        .position     (position)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= HUNT;
            gap        <= '0;
            miss_run   <= '0;
            err_cnt    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap        <= gap_nxt;
            miss_run   <= miss_nxt;
            err_cnt    <= err_nxt;
            mismatch_q <= mismatch_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gap_nxt      = gap;
        miss_nxt     = miss_run;
        err_nxt      = err_cnt;
        mismatch_nxt = 1'b0;
        exp_load     = 1'b0;
        exp_adv      = 1'b0;
        exp_wrap_en  = (state == LOCKED);
        consistent   = (fizzbuzz == (fizz & buzz));
        gap_inc      = gap + GW'(1);
        // In CONFIRM the phase counters were loaded at gap 0, so they track gap % period.
        pattern_bad  = (fizz != exp_fizz) || (buzz != exp_buzz);
        flag_diff    = pattern_bad || (fizzbuzz != exp_fizzbuzz);

        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (consistent && fizzbuzz) begin
                        exp_load = 1'b1;
                        gap_nxt  = '0;
                        miss_nxt = '0;
                        state_nxt = (WRAP_GAP == L) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    gap_nxt = gap_inc;
                    exp_adv = 1'b1;
                    if (fizzbuzz && consistent && gap_inc == GW'(WRAP_GAP)) begin
                        state_nxt = LOCKED;
                        exp_load  = 1'b1;
                        gap_nxt   = '0;
                        miss_nxt  = '0;
                    end else if (fizzbuzz && consistent && gap_inc == GW'(L)) begin
                        exp_load = 1'b1;
                        gap_nxt  = '0;
                    end else if (pattern_bad || !consistent) begin
                        state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    exp_adv = 1'b1;
                    if (flag_diff) begin
                        mismatch_nxt = 1'b1;
                        err_nxt = (err_cnt == '1) ? err_cnt : err_cnt + ERR_CNT_W'(1);
                        if (miss_run == MW'(LOSS_THRESH - 1)) begin
                            state_nxt = HUNT;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss_run + MW'(1);
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    assign locked    = (state == LOCKED);
    assign mismatch  = mismatch_q;
    assign err_count = err_cnt;

endmodule

// File: tb/tb_fizzbuzz_checker.sv
// Scoreboard bench: two checker instances (MAX_CYCLES 100 and 90) share one
// flag stream and are compared against an arithmetic reference model.
module tb_fizzbuzz_checker;

    localparam int MAXA = 100;
    localparam int MAXB = 90;
    localparam int F    = 3;
    localparam int B    = 5;
    localparam int LL   = 15;
    localparam int THR  = 3;

    localparam int M_HUNT = 0;
    localparam int M_CONF = 1;
    localparam int M_LOCK = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        fizz;
    logic        buzz;
    logic        fizzbuzz;
    logic        locked_a;
    logic        mismatch_a;
    logic [6:0]  position_a;
    logic [15:0] err_a;
    logic        locked_b;
    logic        mismatch_b;
    logic [6:0]  position_b;
    logic [15:0] err_b;

    fizzbuzz_checker #(
        .FIZZ(3), .BUZZ(5), .MAX_CYCLES(100), .LOSS_THRESH(3), .ERR_CNT_W(16)
    ) dut_a (
        .clk(clk), .resetn(resetn), .in_valid(in_valid),
        .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
        .locked(locked_a), .position(position_a),
        .mismatch(mismatch_a), .err_count(err_a)
    );

    fizzbuzz_checker #(
        .FIZZ(3), .BUZZ(5), .MAX_CYCLES(90), .LOSS_THRESH(3), .ERR_CNT_W(16)
    ) dut_b (
        .clk(clk), .resetn(resetn), .in_valid(in_valid),
        .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
        .locked(locked_b), .position(position_b),
        .mismatch(mismatch_b), .err_count(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int gap;
        int pos;
        bit pos_known;
        int miss;
        int err;
        bit mism;
    } model_t;

    model_t ma;
    model_t mb;
    model_t qa[$];
    model_t qb[$];
    int     checks = 0;
    int     errors = 0;
    int     gpos   = 0;

    function automatic model_t model_step(model_t m, int maxc, bit rn, bit v,
                                          bit f, bit b, bit fb);
        model_t n;
        int     g;
        int     p;
        int     wg;
        bit     cons;
        bit     bad;
        n = m;
        n.mism = 1'b0;
        wg = maxc - LL * ((maxc - 1) / LL);
        if (!rn) begin
            n = '{mode: M_HUNT, gap: 0, pos: 0, pos_known: 1'b1, miss: 0, err: 0, mism: 1'b0};
            return n;
        end
        if (!v) return n;
        cons = (fb == (f && b));
        case (m.mode)
            M_HUNT: begin
                if (cons && fb) begin
                    if (wg == LL) begin
                        n.mode = M_LOCK; n.pos = 0; n.pos_known = 1'b1; n.miss = 0;
                    end else begin
                        n.mode = M_CONF; n.gap = 0; n.pos_known = 1'b0;
                    end
                end
            end
            M_CONF: begin
                g = m.gap + 1;
                n.gap = g;
                if (fb && cons && g == wg) begin
                    n.mode = M_LOCK; n.pos = 0; n.pos_known = 1'b1; n.miss = 0;
                end else if (fb && cons && g == LL) begin
                    n.gap = 0;
                end else if (f != (g % F == 0) || b != (g % B == 0) || !cons) begin
                    n.mode = M_HUNT;
                end
            end
            default: begin
                p = (m.pos + 1) % maxc;
                n.pos = p;
                bad = (f != (p % F == 0)) || (b != (p % B == 0)) || (fb != (p % LL == 0));
                if (bad) begin
                    n.mism = 1'b1;
                    if (m.err < 65535) n.err = m.err + 1;
                    n.miss = m.miss + 1;
                    if (n.miss == THR) begin
                        n.mode = M_HUNT;
                        n.miss = 0;
                    end
                end else begin
                    n.miss = 0;
                end
            end
        endcase
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input model_t e, input logic lk, input logic mm,
                       input int pos, input int err);
        check({tag, " locked"}, int'(lk), int'(e.mode == M_LOCK));
        check({tag, " mismatch"}, int'(mm), int'(e.mism));
        check({tag, " err_count"}, err, e.err);
        if (e.pos_known) check({tag, " position"}, pos, e.pos);
    endtask

    always @(negedge clk) begin : monitor
        model_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("dut_a", e, locked_a, mismatch_a, int'(position_a), int'(err_a));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("dut_b", e, locked_b, mismatch_b, int'(position_b), int'(err_b));
        end
    end

    task automatic step(input bit rn, input bit v, input bit f, input bit b, input bit fb);
        @(negedge clk);
        resetn   = rn;
        in_valid = v;
        fizz     = f;
        buzz     = b;
        fizzbuzz = fb;
        @(posedge clk);
        ma = model_step(ma, MAXA, rn, v, f, b, fb);
        qa.push_back(ma);
        mb = model_step(mb, MAXB, rn, v, f, b, fb);
        qb.push_back(mb);
    endtask

    // corrupt: bit0 flips fizz, bit1 flips buzz, bit2 flips fizzbuzz
    task automatic send(input logic [2:0] corrupt);
        bit f;
        bit b;
        bit fb;
        f  = ((gpos % F) == 0) ^ corrupt[0];
        b  = ((gpos % B) == 0) ^ corrupt[1];
        fb = ((gpos % LL) == 0) ^ corrupt[2];
        step(1'b1, 1'b1, f, b, fb);
        gpos = (gpos + 1) % MAXA;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    endtask

    initial begin : stimulus
        int lock_idx;
        int lock_pos;
        int r;
        resetn = 1'b0; in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
        ma = '{mode: 0, gap: 0, pos: 0, pos_known: 1'b0, miss: 0, err: 0, mism: 1'b0};
        mb = ma;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("reset locked_a", int'(locked_a), 0);
        check("reset err_a", int'(err_a), 0);
        check("reset position_a", int'(position_a), 0);
        check("reset locked_b", int'(locked_b), 0);

        // Inconsistent fizzbuzz beats must not start acquisition.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("inconsistent no lock b", int'(locked_b), 0);
        check("inconsistent no lock a", int'(locked_a), 0);

        // Clean stream from position 0.
        gpos = 0;
        send(3'b000);
        #1;
        check("b locks on first fizzbuzz", int'(locked_b), 1);
        check("b position at lock", int'(position_b), 0);
        for (int i = 1; i < 100; i++) send(3'b000);
        #1;
        check("a unlocked before wrap", int'(locked_a), 0);
        send(3'b000);
        #1;
        check("a locks at beat 100", int'(locked_a), 1);
        check("a position at lock", int'(position_a), 0);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) idle();
            send(3'b000);
        end
        #1;
        check("clean run err_a", int'(err_a), 0);
        check("clean run locked_a", int'(locked_a), 1);
        check("clean run position_a", int'(position_a), (gpos + MAXA - 1) % MAXA);

        // Capture starting at generator position 37.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        gpos = 37;
        lock_idx = -1;
        lock_pos = -1;
        for (int i = 0; i < 80; i++) begin
            send(3'b000);
            #1;
            if (lock_idx < 0 && locked_a) begin
                lock_idx = i;
                lock_pos = int'(position_a);
            end
        end
        check("lock index from 37", lock_idx, 63);
        check("lock position from 37", lock_pos, 0);

        // Single corrupted beat at position 9.
        for (int i = 0; i < 100 && gpos != 9; i++) send(3'b000);
        send(3'b001);
        #1;
        check("single miss pulse", int'(mismatch_a), 1);
        check("single miss err", int'(err_a), 1);
        check("single miss locked", int'(locked_a), 1);
        send(3'b000);
        #1;
        check("pulse one cycle", int'(mismatch_a), 0);
        check("position after miss", int'(position_a), 10);

        // Idle gap while locked.
        repeat (20) idle();
        #1;
        check("idle holds position", int'(position_a), 10);
        check("idle no pulse", int'(mismatch_a), 0);
        repeat (5) send(3'b000);
        #1;
        check("resume err unchanged", int'(err_a), 1);
        check("resume position", int'(position_a), 15);

        // Three consecutive corrupted beats drop lock.
        for (int i = 0; i < 100 && gpos != 40; i++) send(3'b000);
        send(3'b010);
        send(3'b001);
        #1;
        check("locked after 2 misses", int'(locked_a), 1);
        send(3'b100);
        #1;
        check("lock lost on 3rd miss", int'(locked_a), 0);
        check("3rd miss pulse", int'(mismatch_a), 1);
        check("err after burst", int'(err_a), 4);
        for (int i = 0; i < 100 && gpos != 0; i++) send(3'b000);
        #1;
        check("unlocked before pos 0", int'(locked_a), 0);
        send(3'b000);
        #1;
        check("relock at pos 0", int'(locked_a), 1);
        check("relock position", int'(position_a), 0);

        // One-cycle reset while locked.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("mid reset locked", int'(locked_a), 0);
        check("mid reset err", int'(err_a), 0);
        check("mid reset position", int'(position_a), 0);

        // Randomized stream with idle beats and occasional corruption.
        gpos = $urandom_range(0, MAXA - 1);
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) idle();
            else if (r < 14) send(3'($urandom_range(1, 7)));
            else send(3'b000);
        end

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) begin
            @(negedge clk);
            #1;
        end
        check("scoreboard drained", qa.size() + qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
